// File: rtl/dma_read_arbiter.sv
// dma_read_arbiter: shares one DMA read port among NUM_REQ requesters.
// Round-robin grant starting after the last owner, one outstanding read at
// a time, with a per-access timeout and sticky per-requester abort flags.

// Per-requester sticky timeout flag; a new abort outranks a same-cycle clear.
module dma_rd_err_lane (
    input  logic clk,
    input  logic rst_L,
    input  logic err_clr,
    input  logic err_set,
    output logic err
);
    logic err_q, err_d;

    // clear first, then let a fresh abort override it
    always_comb begin
        err_d = err_q;
        if (err_clr) err_d = 1'b0;
        if (err_set) err_d = 1'b1;
    end

    // flag register
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err = err_q;
endmodule

module dma_read_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int RAM_WID        = 32,
    parameter int RAM_WORD_WID   = 16,
    parameter int TIMEOUT_LEN    = 16,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                       clk,
    input  logic                       rst_L,
    input  logic [NUM_REQ-1:0]         req_read,
    input  logic [NUM_REQ*RAM_WID-1:0] req_addr,
    output logic [RAM_WORD_WID-1:0]    req_word,
    output logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         timeout_err,
    input  logic                       err_clr,
    output logic [RAM_WID-1:0]         ram_dma_addr,
    output logic                       ram_read,
    input  logic [RAM_WORD_WID-1:0]    ram_word,
    input  logic                       ram_valid
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;

    state_t                  state_q, state_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [IDX_W-1:0]        last_q, last_d;
    logic [RAM_WID-1:0]      addr_q, addr_d;
    logic [TIMEOUT_LEN-1:0]  cnt_q, cnt_d;
    logic [NUM_REQ-1:0]      valid_q, valid_d;
    logic [RAM_WORD_WID-1:0] word_q, word_d;
    logic [NUM_REQ-1:0]      err_set;

    // requester i's address is slice i of the packed bus
    logic [NUM_REQ-1:0][RAM_WID-1:0] addr_arr;
    assign addr_arr = req_addr;

    logic                   win_found;
    logic [IDX_W-1:0]       win_idx;
    logic [IDX_W:0]         cand;
    logic                   owner_req;
    logic [TIMEOUT_LEN-1:0] cnt_inc;
    logic                   timeout_hit;

    assign owner_req   = req_read[owner_q];
    assign cnt_inc     = cnt_q + 1'b1;
    // ram_valid on the final cycle still counts as a completed read
    assign timeout_hit = (state_q == ISSUE) && !ram_valid &&
                         (cnt_inc == TIMEOUT_LEN'(TIMEOUT_CYCLES));

    // round-robin search: first set request at last+1, last+2, ... wrapping
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
            if (!win_found && req_read[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // state register plus all datapath flops
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= IDX_W'(NUM_REQ-1);
            addr_q  <= '0;
            cnt_q   <= '0;
            valid_q <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            word_q  <= word_d;
        end
    end

    // next-state: RELEASE waits for the owner to let go and the port to go quiet
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_found) state_d = ISSUE;
            ISSUE:   if (ram_valid || timeout_hit) state_d = RELEASE;
            RELEASE: if (!owner_req && !ram_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // outputs and datapath updates; grant/address are frozen from grant to release
    always_comb begin
        grant_d  = grant_q;
        owner_d  = owner_q;
        last_d   = last_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        valid_d  = '0;
        word_d   = word_q;
        err_set  = '0;
        ram_read = (state_q == ISSUE);
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    owner_d          = win_idx;
                    addr_d           = addr_arr[win_idx];
                    cnt_d            = '0;
                end
            end
            ISSUE: begin
                cnt_d = cnt_inc;
                if (ram_valid) begin
                    valid_d = grant_q;
                    word_d  = ram_word;
                end else if (timeout_hit) begin
                    err_set = grant_q;
                end
            end
            RELEASE: begin
                if (!owner_req && !ram_valid) begin
                    grant_d = '0;
                    last_d  = owner_q;
                end
            end
            default: ;
        endcase
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_err
        dma_rd_err_lane u_lane (
            .clk     (clk),
            .rst_L   (rst_L),
            .err_clr (err_clr),
            .err_set (err_set[i]),
            .err     (timeout_err[i])
        );
    end

    assign grant        = grant_q;
    assign ram_dma_addr = addr_q;
    assign req_valid    = valid_q;
    assign req_word     = word_q;
endmodule
